// File: rtl/serial_word_receiver.sv
// Serial-in/parallel-out receiver: frames WIDTH-bit words MSB- or LSB-first onto a one-deep valid/ready buffer.
// Latency: last bit sampled at edge N -> out_valid after edge N+1; a full, unaccepted buffer drops the word and flags overflow.
module serial_word_receiver #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin_valid,
    input  logic             sin_data,
    input  logic             sin_frame,
    input  logic             dir,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overflow,
    input  logic             clr_ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             vld_q, vld_d;
    logic             ovf_q, ovf_d;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr,
                                                  input logic b, input logic d);
        return d ? {b, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], b};
    endfunction

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        data_d  = data_q;
        vld_d   = vld_q;
        ovf_d   = ovf_q & ~clr_ovf;

        case (state_q)
            ST_IDLE: begin
                if (sin_valid && sin_frame) begin
                    dir_d   = dir;
                    sr_d    = shift_in(sr_q, sin_data, dir);
                    cnt_d   = CW'(1);
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                if (sin_valid) begin
                    if (sin_frame) begin
                        // A mid-word frame restarts assembly with this bit as bit 1.
                        ferr_d = 1'b1;
                        dir_d  = dir;
                        sr_d   = shift_in(sr_q, sin_data, dir);
                        cnt_d  = CW'(1);
                    end else begin
                        sr_d = shift_in(sr_q, sin_data, dir_q);
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            cnt_d   = '0;
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end
        endcase

        // sr_q still holds the completed word here even if a new frame starts this cycle.
        if (done_q) begin
            if (!vld_q || out_ready) begin
                data_d = sr_q;
                vld_d  = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (vld_q && out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            data_q  <= '0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = vld_q;
    assign busy      = (state_q == ST_SHIFT);
    assign frame_err = ferr_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver at WIDTH=4 with hand-computed expected words.
module tb_serial_word_receiver;

    logic       clk = 1'b0;
    logic       rst, sin_valid, sin_data, sin_frame, dir, out_ready, clr_ovf;
    logic [3:0] out_data;
    logic       out_valid, busy, frame_err, overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_word_receiver #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .sin_valid(sin_valid), .sin_data(sin_data), .sin_frame(sin_frame), .dir(dir),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .frame_err(frame_err), .overflow(overflow), .clr_ovf(clr_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of serial input, then sample 1 time unit after the edge.
    task automatic drive(input logic v, input logic d, input logic f);
        sin_valid = v;
        sin_data  = d;
        sin_frame = f;
        @(posedge clk);
        #1;
        sin_valid = 1'b0;
        sin_frame = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) drive(1'b1, w[i], i == 3);
    endtask

    initial begin
        rst = 1'b1; sin_valid = 0; sin_data = 0; sin_frame = 0;
        dir = 0; out_ready = 1; clr_ovf = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ferr", frame_err, 0);
        rst = 1'b0;

        // MSB first 1,0,1,1 -> 1011; dir toggled mid-word must not matter.
        drive(0, 1, 0);
        chk("idle_no_frame_busy", busy, 0);
        drive(1, 1, 1);
        chk("t1_busy", busy, 1);
        dir = 1;
        drive(1, 0, 0);
        drive(1, 1, 0);
        drive(1, 1, 0);
        chk("t1_not_yet", out_valid, 0);
        chk("t1_idle_after", busy, 0);
        drive(0, 0, 0);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 4'b1011);
        drive(0, 0, 0);
        chk("t1_popped", out_valid, 0);
        chk("t1_data_hold", out_data, 4'b1011);

        // LSB first with gaps: 1,0,1,1 -> 1101.
        dir = 1;
        drive(1, 1, 1); drive(0, 0, 0);
        drive(1, 0, 0); drive(0, 0, 0); drive(0, 0, 0);
        drive(1, 1, 0); drive(0, 0, 0);
        drive(1, 1, 0);
        drive(0, 0, 0);
        chk("t2_valid", out_valid, 1);
        chk("t2_data", out_data, 4'b1101);
        drive(0, 0, 0);

        // Back-to-back 0xA then 0x5 with consumer stalled -> 0xA held, overflow.
        dir = 0; out_ready = 0;
        send_word(4'hA);
        send_word(4'h5);
        drive(0, 0, 0);
        chk("t3_valid", out_valid, 1);
        chk("t3_data", out_data, 4'hA);
        chk("t3_ovf", overflow, 1);
        drive(0, 0, 0);
        chk("t3_ovf_sticky", overflow, 1);
        clr_ovf = 1;
        drive(0, 0, 0);
        clr_ovf = 0;
        chk("t3_ovf_clr", overflow, 0);
        out_ready = 1;
        drive(0, 0, 0);
        chk("t3_popped", out_valid, 0);

        // Frame after 2 bits: one frame_err pulse, only 0110 emitted.
        drive(1, 1, 1); drive(1, 1, 0);
        drive(1, 0, 1);
        chk("t4_ferr", frame_err, 1);
        chk("t4_busy", busy, 1);
        drive(1, 1, 0);
        chk("t4_ferr_pulse", frame_err, 0);
        chk("t4_no_partial", out_valid, 0);
        drive(1, 1, 0); drive(1, 0, 0);
        drive(0, 0, 0);
        chk("t4_valid", out_valid, 1);
        chk("t4_data", out_data, 4'b0110);
        chk("t4_no_ovf", overflow, 0);
        drive(0, 0, 0);
        chk("t4_single", out_valid, 0);

        // Reset mid-word after 3 bits, then word 0x3.
        drive(1, 1, 1); drive(1, 1, 0); drive(1, 1, 0);
        rst = 1;
        drive(0, 0, 0);
        rst = 0;
        chk("t5_busy", busy, 0);
        chk("t5_data", out_data, 0);
        chk("t5_valid", out_valid, 0);
        send_word(4'h3);
        drive(0, 0, 0);
        chk("t5_w_valid", out_valid, 1);
        chk("t5_w_data", out_data, 4'h3);
        drive(0, 0, 0);

        // Full buffer accepted in the same cycle the next word lands.
        out_ready = 0;
        send_word(4'h9);
        drive(0, 0, 0);
        chk("t6_first", out_data, 4'h9);
        send_word(4'h6);
        out_ready = 1;
        drive(0, 0, 0);
        chk("t6_valid", out_valid, 1);
        chk("t6_data", out_data, 4'h6);
        chk("t6_no_ovf", overflow, 0);
        drive(0, 0, 0);
        chk("t6_popped", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
